// File: rtl/bc_pkg.sv
// rtl/bc_pkg.sv - shared defaults and interrupt source-index encoding for the I/O controller
package bc_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int NCH_DEF     = 2;

    // Each channel owns two interrupt sources: input-ready at 2c, output-ready at 2c+1.
    localparam int SRC_PER_CH  = 2;
    localparam int SRC_IN_OFS  = 0;
    localparam int SRC_OUT_OFS = 1;

    function automatic int src_idx(input int ch, input logic is_out);
        return SRC_PER_CH * ch + (is_out ? SRC_OUT_OFS : SRC_IN_OFS);
    endfunction

endpackage

// File: rtl/bc_io_chan.sv
// rtl/bc_io_chan.sv - one device channel: INPR/OUTR registers, FGI/FGO flags and handshakes
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid/in_data/in_ready        device-to-CPU character handshake
//   out_valid/out_data/out_ready     CPU-to-device character handshake
//   rd                               CPU INP addressed to this channel (clears FGI)
//   wr, wr_data                      CPU OUT addressed to this channel
//   inpr, fgi, fgo                   register/flag state for the CPU-side mux
module bc_io_chan
    import bc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              rd,
    input  logic              wr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] inpr,
    output logic              fgi,
    output logic              fgo
);

    logic [DATA_W-1:0] outr;

    // FGI=1 means INPR holds an unread character, so the device must wait.
    assign in_ready  = ~fgi;
    // FGO=0 means OUTR holds a character the device has not yet taken.
    assign out_valid = ~fgo;
    assign out_data  = outr;

    // A read arriving while FGI=1 only clears the flag; the device, seeing
    // ready low this cycle, re-presents and is accepted on the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inpr <= '0;
            fgi  <= 1'b0;
        end else if (in_valid && !fgi) begin
            inpr <= in_data;
            fgi  <= 1'b1;
        end else if (rd) begin
            fgi  <= 1'b0;
        end
    end

    // Reset forces FGO=1, which drops out_valid and aborts any pending output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outr <= '0;
            fgo  <= 1'b1;
        end else if (wr && fgo) begin
            outr <= wr_data;
            fgo  <= 1'b0;
        end else if (!fgo && out_ready) begin
            fgo  <= 1'b1;
        end
    end

endmodule

// File: rtl/bc_io_ctrl.sv
// rtl/bc_io_ctrl.sv - multi-channel programmed I/O controller with masked priority interrupt
//
// Ports:
//   clk, rst_n                              clock, async active-low reset
//   dev_in_valid/dev_in_data/dev_in_ready   per-channel device input handshakes
//   dev_out_valid/dev_out_data/dev_out_ready per-channel device output handshakes
//   ch_sel                                  channel addressed by INP/OUT/SKI/SKO
//   inp_rd, inp_data                        INP strobe and INPR of ch_sel
//   out_wr, out_data                        OUT strobe and AC character
//   fgi_sel, fgo_sel                        flags of ch_sel
//   ion, iof                                interrupt enable on/off
//   mask_wr, mask_data                      per-source interrupt mask load
//   int_window, intr_ack                    interrupt sampling window and acknowledge
//   r_flag, ien, intr_vec                   interrupt request, enable, captured source index
module bc_io_ctrl
    import bc_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int NCH    = NCH_DEF,
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCH-1:0]        dev_in_valid,
    input  logic [NCH*DATA_W-1:0] dev_in_data,
    output logic [NCH-1:0]        dev_in_ready,
    output logic [NCH-1:0]        dev_out_valid,
    output logic [NCH*DATA_W-1:0] dev_out_data,
    input  logic [NCH-1:0]        dev_out_ready,
    input  logic [CH_W-1:0]       ch_sel,
    input  logic                  inp_rd,
    input  logic                  out_wr,
    input  logic [DATA_W-1:0]     out_data,
    output logic [DATA_W-1:0]     inp_data,
    output logic                  fgi_sel,
    output logic                  fgo_sel,
    input  logic                  ion,
    input  logic                  iof,
    input  logic                  mask_wr,
    input  logic [2*NCH-1:0]      mask_data,
    input  logic                  int_window,
    input  logic                  intr_ack,
    output logic                  r_flag,
    output logic                  ien,
    output logic [CH_W:0]         intr_vec
);

    logic [NCH-1:0]    sel_oh;
    logic [NCH-1:0]    fgi;
    logic [NCH-1:0]    fgo;
    logic [DATA_W-1:0] inpr [NCH];
    logic [2*NCH-1:0]  mask;
    logic [2*NCH-1:0]  src;
    logic              pending;
    logic [CH_W:0]     low_vec;

    // One-hot channel decode; an out-of-range ch_sel selects nothing, so
    // INP/OUT are ignored and the CPU-side outputs read as zero.
    always_comb begin
        sel_oh = '0;
        for (int c = 0; c < NCH; c++) begin
            sel_oh[c] = (ch_sel == CH_W'(c));
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        bc_io_chan #(
            .DATA_W (DATA_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (dev_in_valid[c]),
            .in_data   (dev_in_data[c*DATA_W +: DATA_W]),
            .in_ready  (dev_in_ready[c]),
            .out_valid (dev_out_valid[c]),
            .out_data  (dev_out_data[c*DATA_W +: DATA_W]),
            .out_ready (dev_out_ready[c]),
            .rd        (inp_rd & sel_oh[c]),
            .wr        (out_wr & sel_oh[c]),
            .wr_data   (out_data),
            .inpr      (inpr[c]),
            .fgi       (fgi[c]),
            .fgo       (fgo[c])
        );
    end

    always_comb begin
        inp_data = '0;
        fgi_sel  = 1'b0;
        fgo_sel  = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (sel_oh[c]) begin
                inp_data = inpr[c];
                fgi_sel  = fgi[c];
                fgo_sel  = fgo[c];
            end
        end
    end

    always_comb begin
        src = '0;
        for (int c = 0; c < NCH; c++) begin
            src[src_idx(c, 1'b0)] = fgi[c] & mask[src_idx(c, 1'b0)];
            src[src_idx(c, 1'b1)] = fgo[c] & mask[src_idx(c, 1'b1)];
        end
    end

    assign pending = |src;

    // Scan from the top down so the lowest pending index is the last write.
    always_comb begin
        low_vec = '0;
        for (int s = 2*NCH-1; s >= 0; s--) begin
            if (src[s]) begin
                low_vec = (CH_W+1)'(s);
            end
        end
    end

    // intr_vec is only captured on the R rising edge, so it stays stable for
    // the whole time the request is outstanding, even if flags or mask move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ien      <= 1'b0;
            r_flag   <= 1'b0;
            intr_vec <= '0;
            mask     <= '0;
        end else begin
            if (mask_wr) begin
                mask <= mask_data;
            end

            if (intr_ack || iof) begin
                ien <= 1'b0;
            end else if (ion) begin
                ien <= 1'b1;
            end

            if (intr_ack) begin
                r_flag <= 1'b0;
            end else if (int_window && ien && pending && !r_flag) begin
                r_flag   <= 1'b1;
                intr_vec <= low_vec;
            end
        end
    end

endmodule

// File: tb/tb_bc_io_ctrl.sv
// tb/tb_bc_io_ctrl.sv - directed plus randomized self-checking bench for bc_io_ctrl
module tb_bc_io_ctrl;

    localparam int DATA_W = 8;
    localparam int NCH    = 2;
    localparam int CH_W   = 1;
    localparam int NSRC   = 2 * NCH;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NCH-1:0]        dev_in_valid;
    logic [NCH*DATA_W-1:0] dev_in_data;
    logic [NCH-1:0]        dev_in_ready;
    logic [NCH-1:0]        dev_out_valid;
    logic [NCH*DATA_W-1:0] dev_out_data;
    logic [NCH-1:0]        dev_out_ready;
    logic [CH_W-1:0]       ch_sel;
    logic                  inp_rd;
    logic                  out_wr;
    logic [DATA_W-1:0]     out_data;
    logic [DATA_W-1:0]     inp_data;
    logic                  fgi_sel;
    logic                  fgo_sel;
    logic                  ion;
    logic                  iof;
    logic                  mask_wr;
    logic [NSRC-1:0]       mask_data;
    logic                  int_window;
    logic                  intr_ack;
    logic                  r_flag;
    logic                  ien;
    logic [CH_W:0]         intr_vec;

    bc_io_ctrl #(
        .DATA_W (DATA_W),
        .NCH    (NCH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dev_in_valid  (dev_in_valid),
        .dev_in_data   (dev_in_data),
        .dev_in_ready  (dev_in_ready),
        .dev_out_valid (dev_out_valid),
        .dev_out_data  (dev_out_data),
        .dev_out_ready (dev_out_ready),
        .ch_sel        (ch_sel),
        .inp_rd        (inp_rd),
        .out_wr        (out_wr),
        .out_data      (out_data),
        .inp_data      (inp_data),
        .fgi_sel       (fgi_sel),
        .fgo_sel       (fgo_sel),
        .ion           (ion),
        .iof           (iof),
        .mask_wr       (mask_wr),
        .mask_data     (mask_data),
        .int_window    (int_window),
        .intr_ack      (intr_ack),
        .r_flag        (r_flag),
        .ien           (ien),
        .intr_vec      (intr_vec)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: the controller as the programmer sees it.
    logic [DATA_W-1:0] m_inpr [NCH];
    logic [DATA_W-1:0] m_outr [NCH];
    bit                m_fgi  [NCH];
    bit                m_fgo  [NCH];
    bit                m_ien;
    bit                m_r;
    bit   [NSRC-1:0]   m_mask;
    int                m_vec;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_inpr[c] = '0;
            m_outr[c] = '0;
            m_fgi[c]  = 1'b0;
            m_fgo[c]  = 1'b1;
        end
        m_ien  = 1'b0;
        m_r    = 1'b0;
        m_mask = '0;
        m_vec  = 0;
    endtask

    function automatic int lowest_pending();
        for (int s = 0; s < NSRC; s++) begin
            bit flag;
            flag = (s % 2 == 1) ? m_fgo[s/2] : m_fgi[s/2];
            if (flag && m_mask[s]) return s;
        end
        return -1;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        int low;
        low = lowest_pending();
        if (intr_ack) begin
            m_r = 1'b0;
        end else if (int_window && m_ien && low >= 0 && !m_r) begin
            m_r   = 1'b1;
            m_vec = low;
        end
        if (intr_ack || iof) m_ien = 1'b0;
        else if (ion)        m_ien = 1'b1;
        if (mask_wr) m_mask = mask_data;
        for (int c = 0; c < NCH; c++) begin
            bit addressed;
            addressed = (int'(ch_sel) == c);
            if (!m_fgi[c] && dev_in_valid[c]) begin
                m_inpr[c] = dev_in_data[c*DATA_W +: DATA_W];
                m_fgi[c]  = 1'b1;
            end else if (inp_rd && addressed) begin
                m_fgi[c]  = 1'b0;
            end
            if (m_fgo[c] && out_wr && addressed) begin
                m_outr[c] = out_data;
                m_fgo[c]  = 1'b0;
            end else if (!m_fgo[c] && dev_out_ready[c]) begin
                m_fgo[c]  = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int sel;
        sel = int'(ch_sel);
        for (int c = 0; c < NCH; c++) begin
            chk("dev_in_ready",  32'(dev_in_ready[c]),  32'(!m_fgi[c]));
            chk("dev_out_valid", 32'(dev_out_valid[c]), 32'(!m_fgo[c]));
            chk("dev_out_data",  32'(dev_out_data[c*DATA_W +: DATA_W]), 32'(m_outr[c]));
        end
        chk("inp_data", 32'(inp_data), 32'(m_inpr[sel]));
        chk("fgi_sel",  32'(fgi_sel),  32'(m_fgi[sel]));
        chk("fgo_sel",  32'(fgo_sel),  32'(m_fgo[sel]));
        chk("r_flag",   32'(r_flag),   32'(m_r));
        chk("ien",      32'(ien),      32'(m_ien));
        chk("intr_vec", 32'(intr_vec), 32'(m_vec));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic clear_inputs();
        dev_in_valid  = '0;
        dev_in_data   = '0;
        dev_out_ready = '0;
        ch_sel        = '0;
        inp_rd        = 1'b0;
        out_wr        = 1'b0;
        out_data      = '0;
        ion           = 1'b0;
        iof           = 1'b0;
        mask_wr       = 1'b0;
        mask_data     = '0;
        int_window    = 1'b0;
        intr_ack      = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        model_reset();

        // Reset state
        @(negedge clk);
        check_all();
        chk("rst_out_valid", 32'(dev_out_valid), 32'h0);
        chk("rst_in_ready",  32'(dev_in_ready),  32'h3);
        rst_n = 1'b1;

        // Input path on channel 1
        dev_in_valid[1] = 1'b1;
        dev_in_data[15:8] = 8'h41;
        tick();
        dev_in_valid[1] = 1'b0;
        ch_sel = 1'b1;
        #1;
        chk("in_fgi1",      32'(fgi_sel),         32'h1);
        chk("in_ready1",    32'(dev_in_ready[1]), 32'h0);
        chk("in_data_comb", 32'(inp_data),        32'h41);
        inp_rd = 1'b1;
        tick();
        inp_rd = 1'b0;
        chk("in_fgi1_clr",  32'(fgi_sel),         32'h0);

        // Output path on channel 0; a second OUT while busy is dropped
        ch_sel = 1'b0;
        out_wr = 1'b1;
        out_data = 8'h5A;
        tick();
        out_data = 8'h33;
        tick();
        out_wr = 1'b0;
        chk("out_valid0", 32'(dev_out_valid[0]),   32'h1);
        chk("out_data0",  32'(dev_out_data[7:0]),  32'h5A);
        dev_out_ready[0] = 1'b1;
        tick();
        dev_out_ready[0] = 1'b0;
        chk("out_fgo0",   32'(fgo_sel),            32'h1);

        // Interrupt from channel 1 input (source 2)
        mask_wr = 1'b1;
        mask_data = 4'b0100;
        ion = 1'b1;
        tick();
        mask_wr = 1'b0;
        ion = 1'b0;
        dev_in_valid[1] = 1'b1;
        dev_in_data[15:8] = 8'h99;
        tick();
        dev_in_valid[1] = 1'b0;
        int_window = 1'b1;
        tick();
        chk("irq_r",   32'(r_flag),   32'h1);
        chk("irq_vec", 32'(intr_vec), 32'h2);
        intr_ack = 1'b1;
        tick();
        intr_ack = 1'b0;
        int_window = 1'b0;
        chk("ack_r",   32'(r_flag), 32'h0);
        chk("ack_ien", 32'(ien),    32'h0);

        // Priority: FGO[0] (source 1) beats FGI[1] (source 2)
        mask_wr = 1'b1;
        mask_data = 4'b1111;
        ion = 1'b1;
        tick();
        mask_wr = 1'b0;
        ion = 1'b0;
        int_window = 1'b1;
        tick();
        chk("prio_vec", 32'(intr_vec), 32'h1);
        ion = 1'b1;
        intr_ack = 1'b1;
        tick();
        ion = 1'b0;
        intr_ack = 1'b0;
        chk("ack_over_ion", 32'(ien), 32'h0);

        // Reset in the middle of an output handshake with R set
        ion = 1'b1;
        int_window = 1'b0;
        tick();
        ion = 1'b0;
        int_window = 1'b1;
        out_wr = 1'b1;
        out_data = 8'h77;
        tick();
        out_wr = 1'b0;
        int_window = 1'b0;
        chk("pre_rst_valid", 32'(dev_out_valid[0]), 32'h1);
        chk("pre_rst_r",     32'(r_flag),           32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_valid", 32'(dev_out_valid[0]), 32'h0);
        chk("async_fgo",   32'(fgo_sel),          32'h1);
        chk("async_r",     32'(r_flag),           32'h0);
        check_all();
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            dev_in_valid  = NCH'($urandom);
            dev_in_data   = (NCH*DATA_W)'($urandom);
            dev_out_ready = NCH'($urandom);
            ch_sel        = CH_W'($urandom);
            inp_rd        = ($urandom_range(0, 3) == 0);
            out_wr        = ($urandom_range(0, 3) == 0);
            out_data      = DATA_W'($urandom);
            ion           = ($urandom_range(0, 7) == 0);
            iof           = ($urandom_range(0, 15) == 0);
            mask_wr       = ($urandom_range(0, 15) == 0);
            mask_data     = NSRC'($urandom);
            int_window    = 1'($urandom);
            intr_ack      = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
